// File: rtl/abro_state_machine_pkg.sv
// ABRO controller shared types: state width and the encoded state enum.
package abro_pkg;

    localparam int STATE_W = 3;

    // Encodings are exposed on the State debug port, so keep them fixed.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_DONE  = 3'd1,
        S_GOT_A = 3'd2,
        S_GOT_B = 3'd3,
        S_HALT  = 3'd4
    } abro_state_t;

endpackage

// File: rtl/abro_state_machine_if.sv
// ABRO event bundle: A/B events in, O event and encoded state out.
interface abro_state_machine_if;
    import abro_pkg::*;

    logic               A;
    logic               B;
    logic               O;
    logic [STATE_W-1:0] State;

    // Event source / observer side.
    modport master (output A, output B, input O, input State);
    // Controller side.
    modport slave  (input A, input B, output O, output State);

endinterface

// File: rtl/abro_state_machine.sv
// ABRO controller: waits for A and B (any order, or together), raises O,
// then stays quiet until reset. Optional macro ABRO_PULSE_EN turns O into
// a single-cycle pulse by parking the FSM in S_HALT after S_DONE.
module abro_state_machine
    import abro_pkg::*;
#(
    parameter int STATE_W = abro_pkg::STATE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               A,
    input  logic               B,
    output logic               O,
    output logic [STATE_W-1:0] State
);

    // The encoding is fixed; reject any other width when elaborating.
    if (STATE_W != 3) begin : g_bad_width
        $error("abro_state_machine: STATE_W must be 3");
    end

    abro_state_t state_q, state_d;
    logic        o_q;

    // Next-state decode; codes 5-7 fall into the default and recover to idle.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (A && B)  state_d = S_DONE;
                else if (A)  state_d = S_GOT_A;
                else if (B)  state_d = S_GOT_B;
                else         state_d = S_IDLE;
            end
            S_GOT_A: state_d = B ? S_DONE : S_GOT_A;
            S_GOT_B: state_d = A ? S_DONE : S_GOT_B;
`ifdef ABRO_PULSE_EN
            S_DONE:  state_d = S_HALT;
`else
            S_DONE:  state_d = S_DONE;
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and O registered together so O moves on the same edge as State.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= (state_d == S_DONE);
        end
    end

    assign O     = o_q;
    assign State = state_q;

endmodule

// File: tb/tb_abro_state_machine.sv
// Directed self-checking bench for abro_state_machine (both builds of
// ABRO_PULSE_EN are handled).
module tb_abro_state_machine;
    import abro_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    abro_state_machine_if bus ();

    abro_state_machine #(.STATE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (bus.A),
        .B     (bus.B),
        .O     (bus.O),
        .State (bus.State)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.A = 1'b1;
        bus.B = 1'b1;
        #1 reset = 1'b0;
        #2;
        checks++;
        if (bus.State !== 3'd0 || bus.O !== 1'b0) begin
            failures++;
            $display("FAIL reset_assert: State=%0d O=%b want State=0 O=0", bus.State, bus.O);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.State !== 3'd0 || bus.O !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_events: State=%0d O=%b want State=0 O=0", bus.State, bus.O);
        end
        bus.A = 1'b0;
        bus.B = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.State !== 3'd0 || bus.O !== 1'b0) begin
                failures++;
                $display("FAIL reset_release_c%0d: State=%0d O=%b want State=0 O=0", i, bus.State, bus.O);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.A = 1'b0;
        bus.B = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic test_a_only();
        bus.A = 1'b1;
        bus.B = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.State !== 3'd2 || bus.O !== 1'b0) begin
                failures++;
                $display("FAIL a_held_c%0d: State=%0d O=%b want State=2 O=0", i, bus.State, bus.O);
            end
        end
        bus.A = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.State !== 3'd2 || bus.O !== 1'b0) begin
                failures++;
                $display("FAIL a_released_c%0d: State=%0d O=%b want State=2 O=0", i, bus.State, bus.O);
            end
        end
    endtask

    task automatic test_b_then_a();
        do_reset();
        bus.B = 1'b1;
        tick();
        checks++;
        if (bus.State !== 3'd3 || bus.O !== 1'b0) begin
            failures++;
            $display("FAIL b_first: State=%0d O=%b want State=3 O=0", bus.State, bus.O);
        end
        bus.A = 1'b1;
        bus.B = 1'b0;
        tick();
        checks++;
        if (bus.State !== 3'd1 || bus.O !== 1'b1) begin
            failures++;
            $display("FAIL b_then_a_done: State=%0d O=%b want State=1 O=1", bus.State, bus.O);
        end
        bus.A = 1'b0;
`ifdef ABRO_PULSE_EN
        tick();
        checks++;
        if (bus.State !== 3'd4 || bus.O !== 1'b0) begin
            failures++;
            $display("FAIL b_then_a_halt: State=%0d O=%b want State=4 O=0", bus.State, bus.O);
        end
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.State !== 3'd1 || bus.O !== 1'b1) begin
                failures++;
                $display("FAIL b_then_a_hold_c%0d: State=%0d O=%b want State=1 O=1", i, bus.State, bus.O);
            end
        end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.A = 1'b1;
        bus.B = 1'b1;
        tick();
        checks++;
        if (bus.State !== 3'd1 || bus.O !== 1'b1) begin
            failures++;
            $display("FAIL simul_done: State=%0d O=%b want State=1 O=1", bus.State, bus.O);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
`ifdef ABRO_PULSE_EN
            if (bus.State !== 3'd4 || bus.O !== 1'b0) begin
                failures++;
                $display("FAIL simul_after_c%0d: State=%0d O=%b want State=4 O=0", i, bus.State, bus.O);
            end
`else
            if (bus.State !== 3'd1 || bus.O !== 1'b1) begin
                failures++;
                $display("FAIL simul_after_c%0d: State=%0d O=%b want State=1 O=1", i, bus.State, bus.O);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.A = 1'b1;
        bus.B = 1'b1;
        tick();
        // Now in S_DONE with A=B=1 held; pull reset between edges.
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.State !== 3'd0 || bus.O !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: State=%0d O=%b want State=0 O=0", bus.State, bus.O);
        end
        #1 reset = 1'b1;
        tick();
        checks++;
        if (bus.State !== 3'd1 || bus.O !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_rearm: State=%0d O=%b want State=1 O=1", bus.State, bus.O);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.A = 1'b1;
        tick();                       // S_GOT_A
        bus.A = 1'b0;
        force dut.state_q = abro_state_t'(3'd6);
        #1 release dut.state_q;
        #1;
        checks++;
        if (bus.State !== 3'd6) begin
            failures++;
            $display("FAIL illegal_injected: State=%0d want State=6", bus.State);
        end
        tick();
        checks++;
        if (bus.State !== 3'd0 || bus.O !== 1'b0) begin
            failures++;
            $display("FAIL illegal_recover: State=%0d O=%b want State=0 O=0", bus.State, bus.O);
        end
        // Recovery must leave the FSM fully functional.
        bus.A = 1'b1;
        bus.B = 1'b1;
        tick();
        checks++;
        if (bus.State !== 3'd1 || bus.O !== 1'b1) begin
            failures++;
            $display("FAIL illegal_then_done: State=%0d O=%b want State=1 O=1", bus.State, bus.O);
        end
        bus.A = 1'b0;
        bus.B = 1'b0;
    endtask

    initial begin
        bus.A = 1'b0;
        bus.B = 1'b0;
        test_reset();
        test_a_only();
        test_b_then_a();
        test_simultaneous();
        test_reset_mid();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
